// File: rtl/obi_pkg.sv
// Minimal OBI bus configuration: only the fields the reliable a_other
// channel width depends on.
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
    int unsigned OptionalWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth:     32,
    DataWidth:     32,
    IdWidth:       1,
    OptionalWidth: 0
  };

endpackage

// File: rtl/relobi_pkg.sv
// Shared widths and scheduler state type for the reliable OBI a_other decode path.
// a_other carries we, byte enables, aid and the optional sideband.
package relobi_pkg;

  typedef enum logic {
    SCHED_RUN  = 1'b0,
    SCHED_HALT = 1'b1
  } sched_state_e;

  // Smallest SECDED check width r with 2^(r-1) >= k + r.
  function automatic int unsigned hsiao_parity_width(int unsigned k);
    int unsigned r = 2;
    while ((1 << (r - 1)) < (k + r)) r++;
    return r;
  endfunction

  function automatic int unsigned relobi_a_other_width(obi_pkg::obi_cfg_t cfg);
    return 1 + cfg.DataWidth / 8 + cfg.IdWidth + cfg.OptionalWidth;
  endfunction

  function automatic int unsigned relobi_a_other_ecc_width(obi_pkg::obi_cfg_t cfg);
    return hsiao_parity_width(relobi_a_other_width(cfg));
  endfunction

endpackage

// File: rtl/hsiao_ecc_dec.sv
// Combinational Hsiao SECDED decoder; input word is {check bits, data}.
// err_o[0]: single error corrected, err_o[1]: uncorrectable (data passed through).
module hsiao_ecc_dec
  import relobi_pkg::*;
#(
  parameter  int unsigned DataWidth  = 32,
  localparam int unsigned ProtWidth  = hsiao_parity_width(DataWidth),
  localparam int unsigned TotalWidth = DataWidth + ProtWidth
) (
  input  logic [TotalWidth-1:0] in_i,
  output logic [DataWidth-1:0]  out_o,
  output logic [1:0]            err_o
);

  // Data columns: the odd-weight (>=3) check vectors in ascending numeric order.
  function automatic logic [DataWidth-1:0][ProtWidth-1:0] gen_cols();
    logic [DataWidth-1:0][ProtWidth-1:0] cols;
    int unsigned n;
    int unsigned w;
    cols = '0;
    n    = 0;
    for (int unsigned v = 0; v < (1 << ProtWidth); v++) begin
      w = 0;
      for (int unsigned b = 0; b < ProtWidth; b++) w += (v >> b) & 1;
      if (w >= 3 && w[0] && n < DataWidth) begin
        cols[n] = v[ProtWidth-1:0];
        n++;
      end
    end
    return cols;
  endfunction

  localparam logic [DataWidth-1:0][ProtWidth-1:0] Cols = gen_cols();

  logic [DataWidth-1:0] raw;
  logic [ProtWidth-1:0] syn;

  always_comb begin
    raw = in_i[DataWidth-1:0];
    syn = in_i[TotalWidth-1:DataWidth];
    for (int i = 0; i < DataWidth; i++) begin
      if (raw[i]) syn = syn ^ Cols[i];
    end
    out_o = raw;
    for (int i = 0; i < DataWidth; i++) begin
      if ((^syn) && (syn == Cols[i])) out_o[i] = ~raw[i];
    end
    err_o = {(syn != '0) && !(^syn), ^syn};
  end

endmodule

// File: rtl/relobi_a_dec_sched.sv
// Round-robin scheduler sharing one a_other SECDED decoder among NumReq requesters.
// One-cycle registered output, full throughput; optional halt after an uncorrectable word.
module relobi_a_dec_sched
  import relobi_pkg::*;
#(
  parameter  obi_pkg::obi_cfg_t Cfg           = obi_pkg::ObiDefaultConfig,
  parameter  int unsigned       NumReq        = 2,
  parameter  int unsigned       CntWidth      = 16,
  parameter  bit                StallOnUncorr = 1'b1,
  localparam int unsigned       AW            = relobi_a_other_width(Cfg),
  localparam int unsigned       EW            = relobi_a_other_ecc_width(Cfg),
  localparam int unsigned       SrcW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq-1:0][AW-1:0]    req_data_i,
  input  logic [NumReq-1:0][EW-1:0]    req_ecc_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [AW-1:0]                out_data_o,
  output logic [SrcW-1:0]              out_src_o,
  output logic [1:0]                   out_err_o,
  output logic                         halted_o,
  input  logic                         err_ack_i,
  input  logic                         clr_cnt_i,
  output logic [CntWidth-1:0]          corr_cnt_o,
  output logic [CntWidth-1:0]          uncorr_cnt_o
);

  localparam logic [SrcW:0] NumReqW = (SrcW + 1)'(NumReq);

  sched_state_e          state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [AW-1:0]         out_data_q, out_data_d;
  logic [SrcW-1:0]       out_src_q, out_src_d;
  logic [1:0]            out_err_q, out_err_d;
  logic [SrcW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CntWidth-1:0]   corr_cnt_q, corr_cnt_d;
  logic [CntWidth-1:0]   uncorr_cnt_q, uncorr_cnt_d;

  logic                  accept;
  logic                  found;
  logic                  gnt_vld;
  logic [SrcW-1:0]       gnt_idx;
  logic [SrcW:0]         cand;
  logic [SrcW:0]         nxt;
  logic [AW+EW-1:0]      dec_in;
  logic [AW-1:0]         dec_data;
  logic [1:0]            dec_err;

  always_comb begin
    accept  = !out_valid_q || out_ready_i;
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, rr_ptr_q} + (SrcW + 1)'(k);
      if (cand >= NumReqW) cand = cand - NumReqW;
      if (!found && req_valid_i[cand[SrcW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[SrcW-1:0];
      end
    end
    // Reset gating keeps the first grant at least one cycle after release.
    gnt_vld     = found && accept && (state_q == SCHED_RUN) && !rst_i;
    req_ready_o = '0;
    if (gnt_vld) req_ready_o[gnt_idx] = 1'b1;
    dec_in = {req_ecc_i[gnt_idx], req_data_i[gnt_idx]};
  end

  hsiao_ecc_dec #(
    .DataWidth (AW)
  ) i_dec (
    .in_i  (dec_in),
    .out_o (dec_data),
    .err_o (dec_err)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    out_err_d    = out_err_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    state_d      = state_q;

    if (accept) out_valid_d = gnt_vld;
    if (gnt_vld) begin
      out_data_d = dec_data;
      out_src_d  = gnt_idx;
      out_err_d  = dec_err;
    end

    nxt = {1'b0, gnt_idx} + (SrcW + 1)'(1);
    if (nxt == NumReqW) nxt = '0;
    rr_ptr_d = gnt_vld ? nxt[SrcW-1:0] : rr_ptr_q;

    if (clr_cnt_i) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else begin
      if (gnt_vld && dec_err[0] && corr_cnt_q != '1)   corr_cnt_d   = corr_cnt_q + CntWidth'(1);
      if (gnt_vld && dec_err[1] && uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + CntWidth'(1);
    end

    unique case (state_q)
      SCHED_RUN:  if (StallOnUncorr && gnt_vld && dec_err[1]) state_d = SCHED_HALT;
      SCHED_HALT: if (err_ack_i) state_d = SCHED_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= SCHED_RUN;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      out_err_q    <= '0;
      rr_ptr_q     <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_err_q    <= out_err_d;
      rr_ptr_q     <= rr_ptr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_src_o    = out_src_q;
  assign out_err_o    = out_err_q;
  assign halted_o     = (state_q == SCHED_HALT);
  assign corr_cnt_o   = corr_cnt_q;
  assign uncorr_cnt_o = uncorr_cnt_q;

endmodule

// File: tb/tb_relobi_a_dec_sched.sv
// Scoreboard bench for relobi_a_dec_sched with default parameters (AW=6, EW=5, NumReq=2).
// Check bits below are hand-computed for the decoder's column set {07,0B,0D,0E,13,15}.
module tb_relobi_a_dec_sched;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][5:0] req_data;
  logic [1:0][4:0] req_ecc;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_data;
  logic [0:0]      out_src;
  logic [1:0]      out_err;
  logic            halted;
  logic            err_ack;
  logic            clr_cnt;
  logic [15:0]     corr_cnt;
  logic [15:0]     uncorr_cnt;

  always #5 clk = ~clk;

  relobi_a_dec_sched dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_data_i   (req_data),
    .req_ecc_i    (req_ecc),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_src_o    (out_src),
    .out_err_o    (out_err),
    .halted_o     (halted),
    .err_ack_i    (err_ack),
    .clr_cnt_i    (clr_cnt),
    .corr_cnt_o   (corr_cnt),
    .uncorr_cnt_o (uncorr_cnt)
  );

  // Clean codewords: 0x15 -> ecc 0x19, 0x2A -> ecc 0x10.
  localparam logic [5:0] D0 = 6'h15;
  localparam logic [4:0] E0 = 5'h19;
  localparam logic [5:0] D1 = 6'h2A;
  localparam logic [4:0] E1 = 5'h10;

  typedef struct {
    logic [5:0] data;
    logic       src;
    logic [1:0] err;
    bit         chk_data;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  logic prev_vld = 1'b0;
  logic prev_hs  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: check req_ready at the falling edge, record the expected word, then advance.
  task automatic tick(input logic [1:0] exp_rdy, input logic [5:0] exp_d, input logic [1:0] exp_e);
    exp_t e;
    @(negedge clk);
    chk("req_ready", req_ready, exp_rdy);
    if (exp_rdy != 2'b00) begin
      e.data     = exp_d;
      e.src      = exp_rdy[1];
      e.err      = exp_e;
      e.chk_data = (exp_e != 2'b10);
      e.cyc      = cyc + 1;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each newly presented output word against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      prev_vld <= 1'b0;
      prev_hs  <= 1'b0;
    end else begin
      if (out_valid && (!prev_vld || prev_hs)) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_out: got data %0h src %0h with nothing expected", out_data, out_src);
        end else begin
          mon_e = sb_q.pop_front();
          chk("out_src", 32'(out_src), 32'(mon_e.src));
          chk("out_err", 32'(out_err), 32'(mon_e.err));
          if (mon_e.chk_data) chk("out_data", 32'(out_data), 32'(mon_e.data));
          chk("out_latency_cycle", cyc, mon_e.cyc);
        end
      end
      prev_vld <= out_valid;
      prev_hs  <= out_valid && out_ready;
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = 2'b11;
    req_data  = {D1, D0};
    req_ecc   = {E1, E0};
    out_ready = 1'b1;
    err_ack   = 1'b0;
    clr_cnt   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with both requesters valid
    tick(2'b00, 6'h00, 2'b00);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_src", 32'(out_src), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_corr", 32'(corr_cnt), 0);
    chk("rst_uncorr", 32'(uncorr_cnt), 0);
    rst = 1'b0;

    // Alternating grants with clean words; err_ack in RUN is ignored
    err_ack = 1'b1;
    tick(2'b01, D0, 2'b00);
    tick(2'b10, D1, 2'b00);
    tick(2'b01, D0, 2'b00);
    tick(2'b10, D1, 2'b00);
    chk("run_ack_ignored", 32'(halted), 0);
    err_ack   = 1'b0;
    req_valid = 2'b00;
    tick(2'b00, 6'h00, 2'b00);

    // Single-bit flip on payload bit 3 of requester 0
    req_data[0] = D0 ^ 6'h08;
    req_valid   = 2'b01;
    tick(2'b01, D0, 2'b01);
    chk("corr_cnt_1", 32'(corr_cnt), 1);
    chk("uncorr_cnt_0", 32'(uncorr_cnt), 0);
    req_valid   = 2'b00;
    req_data[0] = D0;
    tick(2'b00, 6'h00, 2'b00);

    // Double-bit flip on requester 1 -> HALT until err_ack
    req_data[1] = D1 ^ 6'h03;
    req_valid   = 2'b10;
    tick(2'b10, D1, 2'b10);
    chk("halted_after_uncorr", 32'(halted), 1);
    chk("uncorr_cnt_1", 32'(uncorr_cnt), 1);
    req_data[1] = D1;
    req_valid   = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick(2'b00, 6'h00, 2'b00);
      chk("halted_hold", 32'(halted), 1);
    end
    err_ack = 1'b1;
    tick(2'b00, 6'h00, 2'b00);
    err_ack = 1'b0;
    chk("halted_released", 32'(halted), 0);
    tick(2'b01, D0, 2'b00);
    tick(2'b10, D1, 2'b00);
    req_valid = 2'b00;
    tick(2'b00, 6'h00, 2'b00);

    // Backpressure: five stalled cycles, then drain and regrant in one cycle
    req_valid = 2'b11;
    tick(2'b01, D0, 2'b00);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(2'b00, 6'h00, 2'b00);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'(D0));
      chk("stall_src", 32'(out_src), 0);
      chk("stall_err", 32'(out_err), 0);
    end
    out_ready = 1'b1;
    tick(2'b10, D1, 2'b00);
    req_valid = 2'b00;
    tick(2'b00, 6'h00, 2'b00);

    // Counter saturation and clear-wins-over-increment
    req_data[0] = D0 ^ 6'h08;
    req_valid   = 2'b01;
    for (int i = 0; i < 65534; i++) tick(2'b01, D0, 2'b01);
    chk("corr_cnt_ffff", 32'(corr_cnt), 32'hFFFF);
    tick(2'b01, D0, 2'b01);
    chk("corr_cnt_sat", 32'(corr_cnt), 32'hFFFF);
    clr_cnt = 1'b1;
    tick(2'b01, D0, 2'b01);
    clr_cnt = 1'b0;
    chk("corr_cnt_clr", 32'(corr_cnt), 0);
    chk("uncorr_cnt_clr", 32'(uncorr_cnt), 0);
    req_valid   = 2'b00;
    req_data[0] = D0;
    tick(2'b00, 6'h00, 2'b00);

    // Reset while a word is held: discarded, counters cleared, first grant to index 0
    req_data[1] = D1 ^ 6'h01;
    req_valid   = 2'b10;
    tick(2'b10, D1, 2'b01);
    chk("corr_cnt_pre_rst", 32'(corr_cnt), 1);
    req_data[1] = D1;
    req_valid   = 2'b01;
    tick(2'b01, D0, 2'b00);
    out_ready = 1'b0;
    req_valid = 2'b11;
    tick(2'b00, 6'h00, 2'b00);
    chk("held_before_rst", 32'(out_valid), 1);
    rst = 1'b1;
    tick(2'b00, 6'h00, 2'b00);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_src", 32'(out_src), 0);
    chk("mid_rst_err", 32'(out_err), 0);
    chk("mid_rst_corr", 32'(corr_cnt), 0);
    chk("mid_rst_uncorr", 32'(uncorr_cnt), 0);
    chk("mid_rst_halted", 32'(halted), 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick(2'b01, D0, 2'b00);
    req_valid = 2'b00;
    tick(2'b00, 6'h00, 2'b00);
    tick(2'b00, 6'h00, 2'b00);

    chk("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
